apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-high.
Parameters, one per line: name, default, meaning.
REQ-002 ADDR_WIDTH, 8, width of PADDR.
REQ-003 DATA_WIDTH, 8, width of PWDATA and PRDATA.
REQ-004 MEM_DEPTH, 64, number of storage words; valid addresses are 0 to MEM_DEPTH-1.
REQ-005 WAIT_STATES, 0, number of PREADY-low access cycles per transfer; legal range 0-7.
Ports, one per line: name, direction, width, meaning.
REQ-006 PCLK, in, 1, clock; all logic on the rising edge.
REQ-007 PRESET, in, 1, synchronous active-high reset.
REQ-008 PSEL, in, 1, slave select.
REQ-009 PENABLE, in, 1, access phase indicator.
REQ-010 PWRITE, in, 1, 1 = write, 0 = read.
REQ-011 PADDR, in, ADDR_WIDTH, transfer address.
REQ-012 PWDATA, in, DATA_WIDTH, write data.
REQ-013 PREADY, out, 1, transfer completes at the rising edge where PREADY=1.
REQ-014 PRDATA, out, DATA_WIDTH, read data; valid while PREADY=1 and the transfer is a read.
REQ-015 PSLVERR, out, 1, error flag; meaningful only while PREADY=1.

Function
REQ-016 PREADY, PRDATA and PSLVERR SHALL all be registered outputs.
REQ-017 The FSM SHALL have two states, IDLE and ACCESS, plus a 3-bit wait counter cnt.
REQ-018 In IDLE, when PSEL=1 and PENABLE=0 are sampled (setup phase), the block SHALL:
- go to ACCESS;
- latch PADDR, PWRITE and PWDATA;
- load cnt = WAIT_STATES;
- set PREADY = (WAIT_STATES==0);
- set PSLVERR = (WAIT_STATES==0) AND addr_err;
- set PRDATA = mem[PADDR] for a valid-address read, else 0.
REQ-019 addr_err SHALL be 1 when PADDR >= MEM_DEPTH, using full-width compare with no aliasing.
REQ-020 In ACCESS with PSEL=1, PENABLE=1 and PREADY=0, the block SHALL decrement cnt; when cnt==1 it SHALL set PREADY=1 and PSLVERR=addr_err.
REQ-021 In ACCESS with PREADY=1 (completion edge), the block SHALL:
- commit the write if it is a write and the address is valid;
- clear PREADY, PSLVERR and PRDATA;
- return to IDLE.
REQ-022 The access phase SHALL last exactly WAIT_STATES+1 cycles, and PREADY SHALL be high for exactly one cycle per transfer.
REQ-023 A write to an invalid address SHALL leave memory unchanged; a read from an invalid address SHALL return PRDATA=0.
REQ-024 Back-to-back: a setup phase in the cycle immediately after a completion edge SHALL be accepted with no idle cycle.
REQ-025 In IDLE, PENABLE=1 without a preceding setup phase SHALL be ignored: state stays IDLE and PREADY stays 0.
REQ-026 In ACCESS, if PSEL=0 is sampled before completion (abort), the block SHALL return to IDLE with no write and all outputs cleared.
REQ-027 Changes on PADDR, PWRITE or PWDATA during ACCESS SHALL be ignored; the latched values apply.

Reset
REQ-028 While PRESET=1 at a rising edge, the block SHALL set state=IDLE, cnt=0, PREADY=0, PRDATA=0, PSLVERR=0, and clear all memory words to 0.
REQ-029 Reset SHALL override any in-flight transfer; no write is committed at the reset edge.

Structure
REQ-030 Shared package apb_pkg SHALL hold the ADDR_WIDTH and DATA_WIDTH defaults and the state enum apb_slv_state_e {IDLE, ACCESS}.
REQ-031 The storage SHALL be one sub-module, apb_mem_array, with synchronous write, combinational read and synchronous clear.

Verification
REQ-032 WAIT_STATES=0: write 0xA5 to 0x10, then read 0x10 -> PREADY=1 in the first access cycle of each transfer; PRDATA=0xA5; PSLVERR=0.
REQ-033 WAIT_STATES=2: read 0x10 after writing 0x3C -> PREADY low for 2 access cycles and high on the 3rd; PRDATA=0x3C.
REQ-034 Write 0x77 to 0x40, then read 0x40 and read 0x00 -> PSLVERR=1 on both 0x40 transfers; 0x40 read returns 0x00; 0x00 read returns 0x00, confirming no aliasing.
REQ-035 Back-to-back writes 0x01=0x11 and 0x02=0x22 with no idle, then reads -> each PREADY high exactly once; readback returns 0x11 and 0x22.
REQ-036 WAIT_STATES=3: write 0x05=0xFF and drop PSEL in the 2nd access cycle -> no PREADY; read 0x05 returns 0x00.
REQ-037 Assert PRESET during ACCESS of a write 0x06=0x55 -> outputs are 0 the next cycle; read 0x06 returns 0x00; all previously written words read 0x00.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: default bus widths and the slave FSM state type.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// Word storage for the APB slave: synchronous write, combinational read,
// synchronous clear of every word.
module apb_mem_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear wins over a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave backed by a small memory, with a fixed number of wait states and
// an error response for addresses beyond the memory depth.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int         IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int         CMP_WIDTH = ADDR_WIDTH + 32;
  localparam logic [2:0] WS_LOAD   = 3'(WAIT_STATES);
  localparam logic       NO_WAIT   = (WAIT_STATES == 0);

  // Compare on a widened value so an address never aliases onto a valid word.
  function automatic logic is_addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (CMP_WIDTH'(a) >= CMP_WIDTH'(MEM_DEPTH));
  endfunction

  apb_slv_state_e        state;
  logic [2:0]            cnt;
  logic [IDX_WIDTH-1:0]  addr_lat;
  logic                  write_lat;
  logic [DATA_WIDTH-1:0] wdata_lat;
  logic                  err_lat;
  logic                  setup_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign setup_err = is_addr_err(PADDR);
  assign mem_we    = (state == ACCESS) && PREADY && PSEL && write_lat && !err_lat && !PRESET;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_mem (
    .clk   (PCLK),
    .clr   (PRESET),
    .we    (mem_we),
    .waddr (addr_lat),
    .wdata (wdata_lat),
    .raddr (PADDR[IDX_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // Transfer FSM; the read word is captured at setup so PRDATA is registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
      addr_lat  <= '0;
      write_lat <= 1'b0;
      wdata_lat <= '0;
      err_lat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state     <= ACCESS;
            addr_lat  <= PADDR[IDX_WIDTH-1:0];
            write_lat <= PWRITE;
            wdata_lat <= PWDATA;
            err_lat   <= setup_err;
            cnt       <= WS_LOAD;
            PREADY    <= NO_WAIT;
            PSLVERR   <= NO_WAIT && setup_err;
            PRDATA    <= (!PWRITE && !setup_err) ? mem_rdata : '0;
          end
        end
        ACCESS: begin
          // Completion and abort both finish the transfer; the write itself is mem_we.
          if (!PSEL || PREADY) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else if (PENABLE) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              PREADY  <= 1'b1;
              PSLVERR <= err_lat;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: three instances (0, 2 and 3 wait
// states) share one bus; a scoreboard holds the expected response per transfer.
module tb_apb_slave_mem;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic       err;
  } op_t;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         waits;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       PSEL = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PADDR = 8'h00;
  logic [7:0] PWDATA = 8'h00;
  logic [1:0] sel = 2'd0;

  logic       psel_v  [3];
  logic       pready  [3];
  logic [7:0] prdata  [3];
  logic       pslverr [3];

  logic       cur_ready;
  logic [7:0] cur_rdata;
  logic       cur_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 PCLK = ~PCLK;

  assign psel_v[0] = PSEL && (sel == 2'd0);
  assign psel_v[1] = PSEL && (sel == 2'd1);
  assign psel_v[2] = PSEL && (sel == 2'd2);
  assign cur_ready = pready[sel];
  assign cur_rdata = prdata[sel];
  assign cur_err   = pslverr[sel];

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_v[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_v[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_v[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  function automatic int ws_of(input logic [1:0] s);
    case (s)
      2'd0:    return 0;
      2'd1:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic op_t mk_op(input logic w, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] rd, input logic err);
    op_t o;
    o.w = w; o.a = a; o.d = d; o.rd = rd; o.err = err;
    return o;
  endfunction

  task automatic idle(input int n);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  // One APB transfer, entered and left 1 time unit after a rising edge.
  // Bus inputs are scrambled during the access phase; the latched values must win.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int waits,
                      output logic rdy_after);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PWRITE = ~w; PADDR = ~a; PWDATA = ~d;
    waits = 0;
    while (!cur_ready && waits <= 20) begin
      @(posedge PCLK); #1;
      waits++;
    end
    rd = cur_rdata;
    er = cur_err;
    @(posedge PCLK); #1;
    rdy_after = cur_ready;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pready[i] !== 1'b0 || prdata[i] !== 8'h00 || pslverr[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: actual ready=%b rdata=%h err=%b required 0/00/0",
                 i, pready[i], prdata[i], pslverr[i]);
      end
    end
  endtask

  // Runs a list of transfers on the selected instance through the scoreboard.
  task automatic test_ops(input string tag, input logic [1:0] s, input logic b2b, input op_t ops[$]);
    logic [7:0] rd;
    logic       er, rdy_after;
    int         waits;
    exp_t       e;
    sel = s;
    foreach (ops[i]) begin
      e.rd = ops[i].rd; e.err = ops[i].err; e.waits = ws_of(s);
      sb.push_back(e);
      xfer(ops[i].w, ops[i].a, ops[i].d, rd, er, waits, rdy_after);
      if (!b2b) idle(1);
      e = sb.pop_front();
      checks++;
      if (waits !== e.waits) begin
        failures++;
        $display("FAIL %s[%0d] wait_cycles: actual=%0d required=%0d", tag, i, waits, e.waits);
      end
      checks++;
      if (rd !== e.rd) begin
        failures++;
        $display("FAIL %s[%0d] prdata: actual=%h required=%h", tag, i, rd, e.rd);
      end
      checks++;
      if (er !== e.err) begin
        failures++;
        $display("FAIL %s[%0d] pslverr: actual=%b required=%b", tag, i, er, e.err);
      end
      checks++;
      if (rdy_after !== 1'b0) begin
        failures++;
        $display("FAIL %s[%0d] pready_one_cycle: actual=%b required=0", tag, i, rdy_after);
      end
    end
  endtask

  task automatic test_basic();
    op_t ops[$];
    ops.push_back(mk_op(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0));
    test_ops("basic_ws0", 2'd0, 1'b0, ops);
  endtask

  task automatic test_wait_states();
    op_t ops[$];
    ops.push_back(mk_op(1'b1, 8'h10, 8'h3C, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h10, 8'h00, 8'h3C, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h3F, 8'h00, 8'h00, 1'b0));
    test_ops("wait_ws2", 2'd1, 1'b0, ops);
  endtask

  task automatic test_addr_err();
    op_t ops[$];
    ops.push_back(mk_op(1'b1, 8'h40, 8'h77, 8'h00, 1'b1));
    ops.push_back(mk_op(1'b0, 8'h40, 8'h00, 8'h00, 1'b1));
    ops.push_back(mk_op(1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'hFF, 8'h00, 8'h00, 1'b1));
    test_ops("addr_err", 2'd0, 1'b0, ops);
    ops.delete();
    ops.push_back(mk_op(1'b1, 8'h50, 8'h99, 8'h00, 1'b1));
    ops.push_back(mk_op(1'b0, 8'h10, 8'h00, 8'h3C, 1'b0));
    test_ops("addr_err_ws2", 2'd1, 1'b0, ops);
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    ops.push_back(mk_op(1'b1, 8'h01, 8'h11, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b1, 8'h02, 8'h22, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h01, 8'h00, 8'h11, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h02, 8'h00, 8'h22, 1'b0));
    test_ops("back_to_back", 2'd0, 1'b1, ops);
    idle(1);
  endtask

  task automatic test_penable_no_setup();
    op_t ops[$];
    sel = 2'd0;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      checks++;
      if (pready[0] !== 1'b0) begin
        failures++;
        $display("FAIL penable_no_setup cycle%0d: pready actual=%b required=0", i, pready[0]);
      end
    end
    idle(1);
    ops.push_back(mk_op(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0));
    test_ops("after_no_setup", 2'd0, 1'b0, ops);
  endtask

  task automatic test_abort();
    op_t ops[$];
    int  ready_seen;
    sel = 2'd2;
    ready_seen = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h05; PWDATA = 8'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (pready[2] === 1'b1) ready_seen++;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    if (pready[2] === 1'b1) ready_seen++;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK); #1;
      if (pready[2] === 1'b1) ready_seen++;
    end
    PENABLE = 1'b0;
    checks++;
    if (ready_seen != 0) begin
      failures++;
      $display("FAIL abort_no_pready: ready cycles actual=%0d required=0", ready_seen);
    end
    ops.push_back(mk_op(1'b0, 8'h05, 8'h00, 8'h00, 1'b0));
    test_ops("abort_readback", 2'd2, 1'b0, ops);
  endtask

  task automatic test_reset_mid_transfer();
    op_t ops[$];
    sel = 2'd0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h06; PWDATA = 8'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    checks++;
    if (pready[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid pre_ready: actual=%b required=1", pready[0]);
    end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if (pready[0] !== 1'b0 || prdata[0] !== 8'h00 || pslverr[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid outputs: actual ready=%b rdata=%h err=%b required 0/00/0",
               pready[0], prdata[0], pslverr[0]);
    end
    PRESET = 1'b0;
    idle(1);
    ops.push_back(mk_op(1'b0, 8'h06, 8'h00, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h10, 8'h00, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h01, 8'h00, 8'h00, 1'b0));
    ops.push_back(mk_op(1'b0, 8'h02, 8'h00, 8'h00, 1'b0));
    test_ops("reset_clear_ws0", 2'd0, 1'b0, ops);
    ops.delete();
    ops.push_back(mk_op(1'b0, 8'h10, 8'h00, 8'h00, 1'b0));
    test_ops("reset_clear_ws2", 2'd1, 1'b0, ops);
  endtask

  initial begin
    test_reset();
    idle(1);
    test_basic();
    test_wait_states();
    test_addr_err();
    test_back_to_back();
    test_penable_no_setup();
    test_abort();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
